// File: rtl/dp_seq_ctrl.sv
// dp_seq_ctrl: command FIFO plus IDLE/EXEC/WB sequencer driving the
// rf/alu/mux2 datapath.
// Ports: cmd_* host valid/ready command in; dp_* datapath controls out,
// dp_z/dp_v ALU status in; flag_z/flag_v, busy, cmd_done, cmd_err status.
module dp_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [1:0]    cmd_aluc,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [AW-1:0] cmd_rw,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] dp_ra,
  output logic [AW-1:0] dp_rb,
  output logic [AW-1:0] dp_rw,
  output logic          dp_we,
  output logic          dp_s,
  output logic [1:0]    dp_aluc,
  output logic [DW-1:0] dp_rd,
  input  logic          dp_z,
  input  logic          dp_v,
  output logic          flag_z,
  output logic          flag_v,
  output logic          busy,
  output logic          cmd_done,
  output logic          cmd_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 5 + 3 * AW + DW;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t st, nxt;

  logic [EW-1:0] mem [DEPTH];
  logic [PW:0]   wptr, rptr;
  logic          full, empty, push, pop;

  logic [2:0]    h_op;
  logic [1:0]    h_aluc;
  logic [AW-1:0] h_ra, h_rb, h_rw;
  logic [DW-1:0] h_imm;

  logic [1:0]    c_op;
  logic [1:0]    c_aluc;
  logic [AW-1:0] c_ra, c_rb, c_rw;
  logic [DW-1:0] c_imm;
  logic [3:0]    c_cnt;

  logic is_alu, is_ldi, is_cmp, is_rep;
  logic fin, load, fl_upd, dec;

  // extra pointer bit separates full from empty
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) &&
                 (wptr[PW-1:0] == rptr[PW-1:0]);
  assign push  = cmd_valid && !full;
  assign cmd_ready = !full;
  assign busy  = (st != IDLE) || !empty;

  assign {h_op, h_aluc, h_ra, h_rb, h_rw, h_imm} =
    mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        mem[wptr[PW-1:0]] <= {cmd_op, cmd_aluc, cmd_ra,
                              cmd_rb, cmd_rw, cmd_imm};
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  assign is_alu = (c_op == 2'd0);
  assign is_ldi = (c_op == 2'd1);
  assign is_cmp = (c_op == 2'd2);
  assign is_rep = (c_op == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= nxt;
  end

  always_comb begin
    nxt      = st;
    fin      = 1'b0;
    pop      = 1'b0;
    load     = 1'b0;
    fl_upd   = 1'b0;
    dec      = 1'b0;
    cmd_done = 1'b0;
    cmd_err  = 1'b0;
    dp_ra    = '0;
    dp_rb    = '0;
    dp_rw    = '0;
    dp_we    = 1'b0;
    dp_s     = 1'b0;
    dp_aluc  = '0;
    dp_rd    = '0;
    unique case (st)
      IDLE: fin = 1'b1;
      EXEC: begin
        // REP accumulates into its destination
        dp_ra   = is_rep ? c_rw : c_ra;
        dp_rb   = c_rb;
        dp_aluc = c_aluc;
        unique case (1'b1)
          is_alu: begin
            fl_upd = 1'b1;
            nxt    = WB;
          end
          is_ldi: nxt = WB;
          is_cmp: begin
            fl_upd   = 1'b1;
            cmd_done = 1'b1;
            fin      = 1'b1;
          end
          is_rep: begin
            if (c_cnt == 4'd0) begin
              cmd_done = 1'b1;
              fin      = 1'b1;
            end else begin
              fl_upd = 1'b1;
              nxt    = WB;
            end
          end
          default: nxt = IDLE;
        endcase
      end
      WB: begin
        dp_ra   = is_rep ? c_rw : c_ra;
        dp_rb   = c_rb;
        dp_aluc = c_aluc;
        dp_rw   = c_rw;
        dp_we   = 1'b1;
        dp_s    = is_ldi;
        if (is_ldi) dp_rd = c_imm;
        dec = is_rep;
        // flag_v holds this iteration's overflow
        if (is_rep && c_cnt != 4'd1 && !flag_v) begin
          nxt = EXEC;
        end else begin
          cmd_done = 1'b1;
          fin      = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
    if (fin) begin
      pop     = !empty;
      load    = pop && !h_op[2];
      cmd_err = pop && h_op[2];
      nxt     = load ? EXEC : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_op   <= '0;
      c_aluc <= '0;
      c_ra   <= '0;
      c_rb   <= '0;
      c_rw   <= '0;
      c_imm  <= '0;
      c_cnt  <= '0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      if (fl_upd) begin
        flag_z <= dp_z;
        flag_v <= dp_v;
      end
      if (dec) c_cnt <= c_cnt - 4'd1;
      if (load) begin
        c_op   <= h_op[1:0];
        c_aluc <= h_aluc;
        c_ra   <= h_ra;
        c_rb   <= h_rb;
        c_rw   <= h_rw;
        c_imm  <= h_imm;
        c_cnt  <= h_imm[3:0];
      end
    end
  end

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// tb_dp_seq_ctrl: bench for dp_seq_ctrl with a register-file/ALU model
// as the datapath and a command-level reference model of the sequencer.
module tb_dp_seq_ctrl;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [1:0]    cmd_aluc = '0;
  logic [AW-1:0] cmd_ra = '0, cmd_rb = '0, cmd_rw = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic [AW-1:0] dp_ra, dp_rb, dp_rw;
  logic          dp_we, dp_s;
  logic [1:0]    dp_aluc;
  logic [DW-1:0] dp_rd;
  logic          dp_z, dp_v;
  logic          flag_z, flag_v, busy, cmd_done, cmd_err;

  always #5 clk = ~clk;

  dp_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_aluc(cmd_aluc),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rw(cmd_rw),
    .cmd_imm(cmd_imm),
    .dp_ra(dp_ra), .dp_rb(dp_rb), .dp_rw(dp_rw),
    .dp_we(dp_we), .dp_s(dp_s), .dp_aluc(dp_aluc),
    .dp_rd(dp_rd), .dp_z(dp_z), .dp_v(dp_v),
    .flag_z(flag_z), .flag_v(flag_v), .busy(busy),
    .cmd_done(cmd_done), .cmd_err(cmd_err)
  );

  // ALU: 00 add, 01 sub, 10 and, 11 or; returns {v, z, result}
  function automatic logic [33:0] alu(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [1:0] c);
    logic [31:0] r;
    logic v;
    v = 1'b0;
    case (c)
      2'd0: begin
        r = a + b;
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      2'd1: begin
        r = a - b;
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {v, (r == 32'd0), r};
  endfunction

  // datapath environment
  logic [31:0] rf [32];
  logic [33:0] alu_o;
  assign alu_o = alu(rf[dp_ra], rf[dp_rb], dp_aluc);
  assign dp_v = alu_o[33];
  assign dp_z = alu_o[32];
  always @(posedge clk)
    if (dp_we === 1'b1) rf[dp_rw] <= dp_s ? dp_rd : alu_o[31:0];

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  aluc;
    logic [4:0]  ra, rb, rw;
    logic [31:0] imm;
  } cmd_t;

  // one expected output cycle
  typedef struct packed {
    logic [4:0]  ra, rb, rw;
    logic        we, s;
    logic [1:0]  aluc;
    logic [31:0] rd, wd;
    logic        done, src, upd, fz, fv;
  } ph_t;

  cmd_t        fq[$];
  ph_t         phq[$];
  logic [31:0] mr [32];
  logic        fz = 1'b0, fv = 1'b0;
  bit          chk_en = 1'b0;
  int          checks = 0, errors = 0;
  int          we_cnt = 0, done_cnt = 0, err_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // turn one command into its expected cycle sequence
  task automatic expand(input cmd_t c);
    logic [31:0] L [32];
    ph_t p;
    logic [33:0] r;
    int n;
    foreach (mr[i]) L[i] = mr[i];
    p = '0;
    p.src  = 1'b1;
    p.aluc = c.aluc;
    p.rb   = c.rb;
    p.ra   = (c.op == 3'd3) ? c.rw : c.ra;
    case (c.op)
      3'd0: begin
        r = alu(L[c.ra], L[c.rb], c.aluc);
        p.upd = 1; p.fz = r[32]; p.fv = r[33];
        phq.push_back(p);
        p.upd = 0; p.we = 1; p.rw = c.rw;
        p.wd = r[31:0]; p.done = 1;
        phq.push_back(p);
      end
      3'd1: begin
        phq.push_back(p);
        p.we = 1; p.s = 1; p.rw = c.rw; p.src = 0;
        p.rd = c.imm; p.wd = c.imm; p.done = 1;
        phq.push_back(p);
      end
      3'd2: begin
        r = alu(L[c.ra], L[c.rb], c.aluc);
        p.upd = 1; p.fz = r[32]; p.fv = r[33]; p.done = 1;
        phq.push_back(p);
      end
      default: begin
        n = int'(c.imm[3:0]);
        if (n == 0) begin
          p.done = 1;
          phq.push_back(p);
        end else begin
          for (int i = 0; i < n; i++) begin
            r = alu(L[c.rw], L[c.rb], c.aluc);
            p.upd = 1; p.fz = r[32]; p.fv = r[33];
            p.we = 0; p.rw = 0; p.wd = 0; p.done = 0;
            phq.push_back(p);
            p.upd = 0; p.we = 1; p.rw = c.rw; p.wd = r[31:0];
            p.done = (i == n - 1) || r[33];
            phq.push_back(p);
            L[c.rw] = r[31:0];
            if (r[33]) break;
          end
        end
      end
    endcase
  endtask

  // reference model advances at each clock edge
  always @(posedge clk) begin
    ph_t h;
    cmd_t c;
    bit dpop, dpush;
    if (!rst_n) begin
      if (phq.size() > 0 && phq[0].we) mr[phq[0].rw] = phq[0].wd;
      phq.delete();
      fq.delete();
      fz = 1'b0;
      fv = 1'b0;
    end else begin
      dpop  = (fq.size() > 0) && (phq.size() <= 1);
      dpush = cmd_valid && (fq.size() < DEPTH);
      if (phq.size() > 0) begin
        h = phq.pop_front();
        if (h.upd) begin
          fz = h.fz;
          fv = h.fv;
        end
        if (h.we) mr[h.rw] = h.wd;
      end
      if (dpop) begin
        c = fq.pop_front();
        if (!c.op[2]) expand(c);
      end
      if (dpush) begin
        c = {cmd_op, cmd_aluc, cmd_ra, cmd_rb, cmd_rw, cmd_imm};
        fq.push_back(c);
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    ph_t e;
    logic eerr;
    if (chk_en) begin
      e = '0;
      e.src = 1'b1;
      if (phq.size() > 0) e = phq[0];
      eerr = (phq.size() <= 1) && (fq.size() > 0) && fq[0].op[2];
      chk("cmd_ready", cmd_ready, (fq.size() < DEPTH));
      chk("busy", busy, (phq.size() > 0 || fq.size() > 0));
      chk("cmd_done", cmd_done, e.done);
      chk("cmd_err", cmd_err, eerr);
      chk("dp_we", dp_we, e.we);
      chk("dp_s", dp_s, e.s);
      chk("dp_rw", dp_rw, e.rw);
      chk("dp_rd", dp_rd, e.rd);
      chk("flag_z", flag_z, fz);
      chk("flag_v", flag_v, fv);
      if (e.src) begin
        chk("dp_ra", dp_ra, e.ra);
        chk("dp_rb", dp_rb, e.rb);
        chk("dp_aluc", dp_aluc, e.aluc);
      end
      if (e.we) chk("wdata", dp_s ? dp_rd : alu_o[31:0], e.wd);
      we_cnt   += int'(dp_we);
      done_cnt += int'(cmd_done);
      err_cnt  += int'(cmd_err);
    end
  end

  task automatic push(input logic [2:0] op, input logic [1:0] c,
                      input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] w, input logic [31:0] im);
    logic r;
    int n;
    cmd_op = op; cmd_aluc = c; cmd_ra = a; cmd_rb = b;
    cmd_rw = w; cmd_imm = im; cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      r = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 200);
    chk("push_accept", r, 1);
  endtask

  task automatic wait_idle();
    logic b;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      b = busy;
      n++;
    end while (b && n < 500);
    chk("idle_reached", b, 0);
    @(posedge clk);
    #1;
  endtask

  int w0, d0, e0;
  bit found;
  logic [2:0]  r_op;
  logic [31:0] r_imm;
  int sel;

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'd0;
      mr[i] = 32'd0;
    end
    rf[4] = 1; mr[4] = 1;
    rf[5] = 1; mr[5] = 1;
    rf[6] = 32'h7FFF_FFFF; mr[6] = 32'h7FFF_FFFF;
    rf[7] = 1; mr[7] = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", dp_we, 0);
    chk("rst_flags", {flag_z, flag_v}, 0);
    @(posedge clk);
    #1;

    w0 = we_cnt; d0 = done_cnt;
    push(3'd1, 2'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    push(3'd1, 2'd0, 5'd0, 5'd0, 5'd2, 32'd3);
    cmd_valid = 1'b0;
    wait_idle();
    chk("ldi_we_cycles", we_cnt - w0, 2);
    chk("ldi_done", done_cnt - d0, 2);
    chk("r1", rf[1], 5);
    chk("r2", rf[2], 3);

    push(3'd0, 2'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    cmd_valid = 1'b0;
    wait_idle();
    chk("add_r3", rf[3], 8);
    chk("add_flags", {flag_z, flag_v}, 0);

    w0 = we_cnt; d0 = done_cnt;
    push(3'd2, 2'd1, 5'd1, 5'd1, 5'd0, 32'd0);
    cmd_valid = 1'b0;
    wait_idle();
    chk("cmp_z", flag_z, 1);
    chk("cmp_we", we_cnt - w0, 0);
    chk("cmp_done", done_cnt - d0, 1);

    w0 = we_cnt; d0 = done_cnt;
    push(3'd3, 2'd0, 5'd0, 5'd5, 5'd4, 32'd3);
    cmd_valid = 1'b0;
    wait_idle();
    chk("rep_r4", rf[4], 4);
    chk("rep_we", we_cnt - w0, 3);
    chk("rep_done", done_cnt - d0, 1);

    w0 = we_cnt;
    push(3'd3, 2'd0, 5'd0, 5'd7, 5'd6, 32'd5);
    cmd_valid = 1'b0;
    wait_idle();
    chk("ovf_r6", rf[6], 32'h8000_0000);
    chk("ovf_v", flag_v, 1);
    chk("ovf_we", we_cnt - w0, 1);

    e0 = err_cnt;
    push(3'd3, 2'd3, 5'd0, 5'd0, 5'd1, 32'd15);
    push(3'd1, 2'd0, 5'd0, 5'd0, 5'd2, 32'd7);
    push(3'd6, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    push(3'd0, 2'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    push(3'd2, 2'd1, 5'd3, 5'd3, 5'd0, 32'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("full_ready", cmd_ready, 0);
    @(posedge clk);
    #1;
    push(3'd1, 2'd0, 5'd0, 5'd0, 5'd5, 32'd1);
    cmd_valid = 1'b0;
    wait_idle();
    chk("illegal_err", err_cnt - e0, 1);
    chk("fill_r3", rf[3], 12);

    push(3'd0, 2'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    push(3'd1, 2'd0, 5'd0, 5'd0, 5'd5, 32'd9);
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dp_we) begin
        found = 1'b1;
        break;
      end
    end
    chk("wb_seen", found, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstwb_we", dp_we, 0);
    chk("rstwb_busy", busy, 0);
    chk("rstwb_ready", cmd_ready, 1);
    @(posedge clk);
    #1;

    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) r_op = 3'd0;
      else if (sel < 5) r_op = 3'd1;
      else if (sel < 7) r_op = 3'd2;
      else if (sel < 9) r_op = 3'd3;
      else r_op = 3'($urandom_range(4, 7));
      r_imm = $urandom;
      if (r_op == 3'd1 && $urandom_range(0, 3) == 0)
        r_imm = ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFF
                                            : 32'h8000_0000;
      if (r_op == 3'd3) r_imm[3:0] = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      push(r_op, 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), r_imm);
    end
    cmd_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 8; i++)
      chk($sformatf("rf%0d", i), rf[i], mr[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
